// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side bus bundle for mem_arbiter
// slave = arbiter side, master = requesters plus memory (testbench side).
interface mem_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 16
);
  logic              f_req;
  logic [AWIDTH-1:0] f_addr;
  logic [WIDTH-1:0]  f_rdata;
  logic              f_done;
  logic              d_req;
  logic              d_we;
  logic [AWIDTH-1:0] d_addr;
  logic [WIDTH-1:0]  d_wdata;
  logic [WIDTH-1:0]  d_rdata;
  logic              d_done;
  logic              mem_en;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_ready;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output f_rdata, f_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  f_rdata, f_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of fetch and load/store onto one memory port
// IDLE grants and latches the request, ACCESS waits for mem_ready or timeout, DONE pulses done.
module mem_arbiter #(
  parameter int WIDTH   = 16,
  parameter int AWIDTH  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus,
  output logic           busy,
  output logic           timeout_err
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Counter only ever holds 0..TIMEOUT-1; the last value forces DONE.
  localparam int             CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic              r_last_d;
  logic              r_gnt_d;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_f_rdata;
  logic [WIDTH-1:0]  r_d_rdata;
  logic [CW-1:0]     r_cnt;
  logic              r_terr;

  logic              w_any_req;
  logic              w_pick_d;

  assign w_any_req = bus.f_req | bus.d_req;
  // Under contention the requester not granted last wins.
  assign w_pick_d  = bus.d_req & (~bus.f_req | ~r_last_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b0;
      r_gnt_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
      r_cnt     <= '0;
      r_terr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state  <= S_ACCESS;
            r_gnt_d  <= w_pick_d;
            r_last_d <= w_pick_d;
            r_addr   <= w_pick_d ? bus.d_addr : bus.f_addr;
            r_we     <= w_pick_d & bus.d_we;
            r_wdata  <= w_pick_d ? bus.d_wdata : '0;
            r_cnt    <= '0;
          end
        end
        S_ACCESS: begin
          if (bus.mem_ready) begin
            if (!r_we) begin
              if (r_gnt_d) r_d_rdata <= bus.mem_rdata;
              else         r_f_rdata <= bus.mem_rdata;
            end
            r_state <= S_DONE;
          end else if (r_cnt == C_LAST) begin
            r_state <= S_DONE;
            r_terr  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = (r_state == S_ACCESS);
  assign bus.mem_we    = (r_state == S_ACCESS) & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.f_rdata   = r_f_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.f_done    = (r_state == S_DONE) & ~r_gnt_d;
  assign bus.d_done    = (r_state == S_DONE) & r_gnt_d;
  assign busy          = (r_state != S_IDLE);
  assign timeout_err   = r_terr;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data word width.
REQ-002 Parameter AWIDTH, default 16: memory address width.
REQ-003 Parameter TIMEOUT, default 15: max ACCESS cycles waiting for mem_ready.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  in  1  reset, asynchronous, active-low.
REQ-006 Port f_req  in  1  fetch requester read request.
REQ-007 Port f_addr  in  AWIDTH  fetch read address.
REQ-008 Port f_rdata  out  WIDTH  fetch read data, registered.
REQ-009 Port f_done  out  1  one-cycle fetch completion pulse.
REQ-010 Port d_req  in  1  load/store requester request.
REQ-011 Port d_we  in  1  1 = store, 0 = load.
REQ-012 Port d_addr  in  AWIDTH  load/store address.
REQ-013 Port d_wdata  in  WIDTH  store data.
REQ-014 Port d_rdata  out  WIDTH  load data, registered.
REQ-015 Port d_done  out  1  one-cycle load/store completion pulse.
REQ-016 Ports mem_en (out 1), mem_we (out 1), mem_addr (out AWIDTH), mem_wdata (out WIDTH): single-port memory command.
REQ-017 Ports mem_rdata (in WIDTH), mem_ready (in 1): memory response; mem_rdata valid when mem_ready=1.
REQ-018 Ports busy (out 1, high when state != IDLE), timeout_err (out 1, sticky).

Function
REQ-019 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when f_req|d_req; ACCESS->DONE on mem_ready=1 or timeout; DONE->IDLE unconditionally.
REQ-020 Arbitration in IDLE: single requester granted; both requesting -> grantee is the one not granted last (round-robin); last-granted register updates at grant.
REQ-021 At the IDLE->ACCESS edge, grantee identity, address, we (0 for fetch) and wdata are latched; mem_addr/mem_we/mem_wdata driven from latches only.
REQ-022 mem_en=1 exactly while in ACCESS; mem_we=latched we in ACCESS, 0 otherwise.
REQ-023 ACCESS with mem_ready=1 and read: mem_rdata captured into grantee's rdata register at that edge; store leaves d_rdata unchanged.
REQ-024 grantee's done = 1 exactly during DONE; the other done stays 0; f_done and d_done never both 1.
REQ-025 Minimum latency: req high in cycle 0, mem_en in cycle 1, mem_ready in cycle 1 -> done in cycle 2, IDLE in cycle 3.
REQ-026 Requester holds req and operands until done; req sampled high again in IDLE is a new request (no lockout).
REQ-027 req dropped or operands changed during ACCESS/DONE: ignored; access completes on latched values, done still pulses.
REQ-028 Timeout counter: cleared at IDLE->ACCESS, increments each ACCESS cycle without mem_ready; reaching TIMEOUT forces DONE, sets timeout_err, rdata unchanged.
REQ-029 mem_ready in IDLE or DONE is ignored.
REQ-030 timeout_err cleared only by reset.

Reset
REQ-031 reset=0 asynchronously forces state IDLE, last-granted=fetch (first contention grants load/store), counter 0.
REQ-032 During reset: mem_en, mem_we, f_done, d_done, busy, timeout_err = 0; mem_addr, mem_wdata, f_rdata, d_rdata = 0.
REQ-033 Reset mid-ACCESS aborts access immediately, no done pulse; operation resumes on first rising edge after reset=1.

Verification
REQ-034 f_req=1, f_addr=0x0010, mem_ready=1 at cycle 1 with mem_rdata=0xBEEF -> mem_en cycle 1, f_done cycle 2, f_rdata=0xBEEF.
REQ-035 After reset, f_req=d_req=1 held, d_we=1, d_addr=0x0020, d_wdata=0x1234 -> store granted first (mem_we=1, mem_addr=0x0020, mem_wdata=0x1234), then fetch; d_done precedes f_done.
REQ-036 Both requesters continuously requesting over 6 accesses -> grants alternate D,F,D,F,D,F.
REQ-037 d_req=1 load, mem_ready held 0 -> DONE after 15 ACCESS cycles, d_done pulses, d_rdata unchanged, timeout_err=1 until reset.
REQ-038 reset asserted in cycle 1 of ACCESS -> mem_en=0 immediately, no done; after release with f_req=1, normal fetch completes.
REQ-039 d_addr changed 0x0020->0x0030 during ACCESS -> mem_addr stays 0x0020 until DONE.
